// File: rtl/uart_pkt_scheduler.sv
// -----------------------------------------------------------------------------
// uart_pkt_scheduler
//
// Shares one UART transmitter between two 32-bit data producers. In IDLE it
// round-robin arbitrates between the request lines and captures the granted
// word. It then frames the word into a 7-byte packet:
//   SYNC, {src, seq[6:0]}, data[31:24], data[23:16], data[15:8], data[7:0],
//   XOR checksum of bytes 1-5
// Bytes go to the UART one at a time through its tx_ready/tx_en handshake.
//
// Ports
//   clk       system clock
//   reset_b   asynchronous active-low reset
//   req       per-source request level; data must be held stable until ack
//   req_data  source 0 word in [31:0], source 1 word in [63:32]
//   ack       one-cycle pulse: that source's word has been captured
//   tx_ready  UART transmitter ready-to-send
//   tx_en     one-cycle byte strobe to the UART
//   tx_data   byte to the UART, valid while tx_en is high
//   busy      high from capture until the packet completes
//   pkt_done  one-cycle pulse after the last byte has been accepted
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module uart_pkt_scheduler #(
  parameter int         NUM_SRC      = 2,
  parameter int         BUSY_TIMEOUT = 255,
  parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
  input  logic                    clk,
  input  logic                    reset_b,
  input  logic [NUM_SRC-1:0]      req,
  input  logic [32*NUM_SRC-1:0]   req_data,
  output logic [NUM_SRC-1:0]      ack,
  input  logic                    tx_ready,
  output logic                    tx_en,
  output logic [7:0]              tx_data,
  output logic                    busy,
  output logic                    pkt_done
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(BUSY_TIMEOUT);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND      = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_IDLE = 2'd3
  } state_t;

  state_t               state_reg, state_next;
  logic [2:0]           idx_reg, idx_next;
  logic [7:0]           cnt_reg, cnt_next;
  logic [31:0]          data_reg, data_next;
  logic [7:0]           id_reg, id_next;
  logic [7:0]           csum_reg, csum_next;
  logic                 last_grant_reg, last_grant_next;
  logic [NUM_SRC-1:0]   ack_reg, ack_next;
  logic                 tx_en_reg, tx_en_next;
  logic [7:0]           tx_data_reg, tx_data_next;
  logic                 busy_reg, busy_next;
  logic                 pkt_done_reg, pkt_done_next;

  logic [NUM_SRC-1:0]   seq_inc;
  logic [6:0]           seq_cur [NUM_SRC];
  logic [31:0]          src_data [NUM_SRC];

  logic                 grant;
  logic [31:0]          sel_data;
  logic [7:0]           sel_id;
  logic [7:0]           sel_csum;
  logic [7:0]           cur_byte;

  // Per-source data slices and sequence counters. A counter only advances on
  // its own source's completed packet, so an abandoned packet costs no seq.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
      logic [6:0] seq_reg;

      assign src_data[gi] = req_data[32*gi +: 32];
      assign seq_cur[gi]  = seq_reg;

      always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
          seq_reg <= 7'd0;
        end else if (seq_inc[gi]) begin
          seq_reg <= seq_reg + 7'd1;
        end
      end
    end
  endgenerate

  // Round robin: with both requesting, the source not granted last time wins.
  // last_grant resets to 1 so source 0 wins the first contention.
  always_comb begin
    grant = req[1];
    if (req[0] && req[1]) begin
      grant = ~last_grant_reg;
    end
  end

  assign sel_data = src_data[grant];
  assign sel_id   = {grant, seq_cur[grant]};
  assign sel_csum = sel_id ^ sel_data[31:24] ^ sel_data[23:16]
                  ^ sel_data[15:8] ^ sel_data[7:0];

  // Packet byte selected by the current index.
  always_comb begin
    cur_byte = SYNC_BYTE;
    case (idx_reg)
      3'd0:    cur_byte = SYNC_BYTE;
      3'd1:    cur_byte = id_reg;
      3'd2:    cur_byte = data_reg[31:24];
      3'd3:    cur_byte = data_reg[23:16];
      3'd4:    cur_byte = data_reg[15:8];
      3'd5:    cur_byte = data_reg[7:0];
      3'd6:    cur_byte = csum_reg;
      default: cur_byte = SYNC_BYTE;
    endcase
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_next      = state_reg;
    idx_next        = idx_reg;
    cnt_next        = cnt_reg;
    data_next       = data_reg;
    id_next         = id_reg;
    csum_next       = csum_reg;
    last_grant_next = last_grant_reg;
    ack_next        = '0;
    tx_en_next      = 1'b0;
    tx_data_next    = tx_data_reg;
    busy_next       = busy_reg;
    pkt_done_next   = 1'b0;
    seq_inc         = '0;

    case (state_reg)
      IDLE: begin
        if (|req) begin
          data_next       = sel_data;
          id_next         = sel_id;
          csum_next       = sel_csum;
          last_grant_next = grant;
          ack_next[grant] = 1'b1;
          busy_next       = 1'b1;
          idx_next        = 3'd0;
          state_next      = SEND;
        end
      end

      SEND: begin
        if (tx_ready) begin
          tx_en_next   = 1'b1;
          tx_data_next = cur_byte;
          cnt_next     = 8'd0;
          state_next   = WAIT_BUSY;
        end
      end

      // Wait for the UART to show it took the byte. A UART that never drops
      // ready would otherwise stall us forever, so the counter bounds the wait.
      WAIT_BUSY: begin
        if (!tx_ready || (cnt_reg == TIMEOUT_CNT)) begin
          state_next = WAIT_IDLE;
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
      end

      WAIT_IDLE: begin
        if (tx_ready) begin
          if (idx_reg == 3'd6) begin
            pkt_done_next       = 1'b1;
            busy_next           = 1'b0;
            seq_inc[id_reg[7]]  = 1'b1;
            state_next          = IDLE;
          end else begin
            idx_next   = idx_reg + 3'd1;
            state_next = SEND;
          end
        end
      end

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_reg      <= IDLE;
      idx_reg        <= 3'd0;
      cnt_reg        <= 8'd0;
      data_reg       <= 32'd0;
      id_reg         <= 8'd0;
      csum_reg       <= 8'd0;
      last_grant_reg <= 1'b1;
      ack_reg        <= '0;
      tx_en_reg      <= 1'b0;
      tx_data_reg    <= 8'h00;
      busy_reg       <= 1'b0;
      pkt_done_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      idx_reg        <= idx_next;
      cnt_reg        <= cnt_next;
      data_reg       <= data_next;
      id_reg         <= id_next;
      csum_reg       <= csum_next;
      last_grant_reg <= last_grant_next;
      ack_reg        <= ack_next;
      tx_en_reg      <= tx_en_next;
      tx_data_reg    <= tx_data_next;
      busy_reg       <= busy_next;
      pkt_done_reg   <= pkt_done_next;
    end
  end

  assign ack      = ack_reg;
  assign tx_en    = tx_en_reg;
  assign tx_data  = tx_data_reg;
  assign busy     = busy_reg;
  assign pkt_done = pkt_done_reg;

endmodule

// File: tb/tb_uart_pkt_scheduler.sv
// -----------------------------------------------------------------------------
// tb_uart_pkt_scheduler
//
// Directed bench for uart_pkt_scheduler. A small UART model drops tx_ready
// for low_cycles clocks after each tx_en (or keeps it high when stuck=1) and
// records every byte. Stimulus runs at the falling edge; the model samples
// one ns after the rising edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_uart_pkt_scheduler;

  logic        clk = 1'b0;
  logic        reset_b;
  logic [1:0]  req;
  logic [63:0] req_data;
  logic [1:0]  ack;
  logic        tx_ready;
  logic        tx_en;
  logic [7:0]  tx_data;
  logic        busy;
  logic        pkt_done;

  uart_pkt_scheduler #(
    .NUM_SRC      (2),
    .BUSY_TIMEOUT (255),
    .SYNC_BYTE    (8'hA5)
  ) dut (
    .clk      (clk),
    .reset_b  (reset_b),
    .req      (req),
    .req_data (req_data),
    .ack      (ack),
    .tx_ready (tx_ready),
    .tx_en    (tx_en),
    .tx_data  (tx_data),
    .busy     (busy),
    .pkt_done (pkt_done)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // UART model configuration (written by stimulus only)
  int low_cycles = 20;
  bit stuck      = 1'b0;

  // Model / monitor state (written by the model only)
  logic [7:0] byte_q    [$];
  int         en_time_q [$];
  int         ack_src_q [$];
  int ack0_cnt = 0;
  int ack1_cnt = 0;
  int done_cnt = 0;
  int dbl_en_err = 0;
  int en_not_ready_err = 0;
  int busy_err = 0;
  int cycle = 0;
  int busy_cnt = 0;
  bit en_prev = 1'b0;
  bit inflight = 1'b0;

  // Read pointers (written by stimulus only)
  int rd_idx = 0;
  int ack_rd = 0;

  // UART model and monitor
  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      cycle++;
      if (reset_b !== 1'b1) begin
        tx_ready = 1'b1;
        busy_cnt = 0;
        en_prev  = 1'b0;
        inflight = 1'b0;
      end else begin
        if (ack[0]) begin ack0_cnt++; ack_src_q.push_back(0); inflight = 1'b1; end
        if (ack[1]) begin ack1_cnt++; ack_src_q.push_back(1); inflight = 1'b1; end
        if (pkt_done) begin done_cnt++; inflight = 1'b0; end
        if (busy !== inflight) busy_err++;
        if (tx_en) begin
          if (en_prev) dbl_en_err++;
          if (!tx_ready) en_not_ready_err++;
          byte_q.push_back(tx_data);
          en_time_q.push_back(cycle);
          if (!stuck) begin
            tx_ready = 1'b0;
            busy_cnt = low_cycles;
          end
        end else if (busy_cnt > 0) begin
          busy_cnt--;
          if (busy_cnt == 0) tx_ready = 1'b1;
        end
        en_prev = tx_en;
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: observed time limit reached, required $finish before it");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ack(input int src, input string tag);
    int c;
    c = 0;
    while (ack[src] !== 1'b1 && c < 3000) begin
      @(negedge clk);
      c++;
    end
    check({tag, " ack"}, 32'(ack[src]), 32'd1);
  endtask

  task automatic wait_done(input int base, input int n, input string tag);
    int c;
    c = 0;
    while ((done_cnt - base) < n && c < 6000) begin
      @(negedge clk);
      c++;
    end
    check({tag, " pkt_done count"}, 32'(done_cnt - base), 32'(n));
  endtask

  task automatic check_pkt(input logic [7:0] id, input logic [31:0] d,
                           input logic [7:0] csum, input string tag);
    logic [7:0] exp_b [7];
    logic [7:0] got;
    int c;
    exp_b[0] = 8'hA5;
    exp_b[1] = id;
    exp_b[2] = d[31:24];
    exp_b[3] = d[23:16];
    exp_b[4] = d[15:8];
    exp_b[5] = d[7:0];
    exp_b[6] = csum;
    c = 0;
    while ((byte_q.size() - rd_idx) < 7 && c < 4000) begin
      @(negedge clk);
      c++;
    end
    for (int i = 0; i < 7; i++) begin
      got = (byte_q.size() > rd_idx) ? byte_q[rd_idx] : 8'hxx;
      check($sformatf("%s byte%0d", tag, i), 32'(got), 32'(exp_b[i]));
      rd_idx++;
    end
    $display("pkt %s: id=%02h data=%08h csum=%02h", tag, id, d, csum);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_b = 1'b0;
    req     = 2'b00;
    repeat (3) @(negedge clk);
    reset_b = 1'b1;
    repeat (2) @(negedge clk);
    rd_idx = byte_q.size();
    ack_rd = ack_src_q.size();
  endtask

  int a0, a1, d0, e0, base, c, gap;
  logic [7:0]  eid;
  int          exp_order [4] = '{0, 1, 0, 1};
  logic [7:0]  t3_id   [4]   = '{8'h00, 8'h80, 8'h01, 8'h81};
  logic [31:0] t3_data [4]   = '{32'h12345678, 32'hDEADBEEF, 32'h12345678, 32'hDEADBEEF};
  logic [7:0]  t3_csum [4]   = '{8'h08, 8'hA2, 8'h09, 8'hA3};

  initial begin
    reset_b  = 1'b0;
    req      = 2'b00;
    req_data = 64'd0;
    repeat (3) @(negedge clk);
    check("reset ack",      32'(ack),      32'h0);
    check("reset tx_en",    32'(tx_en),    32'h0);
    check("reset tx_data",  32'(tx_data),  32'h0);
    check("reset busy",     32'(busy),     32'h0);
    check("reset pkt_done", 32'(pkt_done), 32'h0);
    reset_b = 1'b1;
    repeat (2) @(negedge clk);
    $display("reset: outputs checked");

    // T1: source 0 alone
    a0 = ack0_cnt; a1 = ack1_cnt; d0 = done_cnt;
    req_data = {32'h0, 32'h12345678};
    req      = 2'b01;
    wait_ack(0, "t1");
    req = 2'b00;
    check_pkt(8'h00, 32'h12345678, 8'h08, "t1");
    wait_done(d0, 1, "t1");
    check("t1 ack0 pulses", 32'(ack0_cnt - a0), 32'd1);
    check("t1 ack1 pulses", 32'(ack1_cnt - a1), 32'd0);

    // T2: source 1 alone, busy held for the whole packet
    d0 = done_cnt;
    req_data = {32'hDEADBEEF, 32'h0};
    req      = 2'b10;
    wait_ack(1, "t2");
    check("t2 busy at ack", 32'(busy), 32'd1);
    req = 2'b00;
    check_pkt(8'h80, 32'hDEADBEEF, 8'hA2, "t2");
    wait_done(d0, 1, "t2");
    check("t2 busy after done", 32'(busy), 32'd0);
    check("t2 busy tracking errors", 32'(busy_err), 32'd0);

    // T3: both requesting from reset, four packets alternate
    do_reset();
    d0 = done_cnt;
    base = ack0_cnt + ack1_cnt;
    req_data = {32'hDEADBEEF, 32'h12345678};
    req      = 2'b11;
    c = 0;
    while ((ack0_cnt + ack1_cnt - base) < 4 && c < 4000) begin
      @(negedge clk);
      c++;
    end
    req = 2'b00;
    check("t3 ack count", 32'(ack0_cnt + ack1_cnt - base), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t3 grant order %0d", i),
            (ack_src_q.size() > ack_rd + i) ? 32'(ack_src_q[ack_rd + i]) : 32'hFFFF_FFFF,
            32'(exp_order[i]));
    end
    for (int i = 0; i < 4; i++) begin
      check_pkt(t3_id[i], t3_data[i], t3_csum[i], $sformatf("t3 #%0d", i));
    end
    wait_done(d0, 4, "t3");

    // T4: reset in the middle of a packet
    do_reset();
    req_data = {32'h0, 32'h12345678};
    req      = 2'b01;
    wait_ack(0, "t4");
    req = 2'b00;
    c = 0;
    while ((byte_q.size() - rd_idx) < 4 && c < 2000) begin
      @(negedge clk);
      c++;
    end
    check("t4 bytes before reset", 32'(byte_q.size() - rd_idx), 32'd4);
    reset_b = 1'b0;
    #1;
    check("t4 mid reset ack",      32'(ack),      32'h0);
    check("t4 mid reset tx_en",    32'(tx_en),    32'h0);
    check("t4 mid reset tx_data",  32'(tx_data),  32'h0);
    check("t4 mid reset busy",     32'(busy),     32'h0);
    check("t4 mid reset pkt_done", 32'(pkt_done), 32'h0);
    repeat (3) @(negedge clk);
    reset_b = 1'b1;
    repeat (2) @(negedge clk);
    rd_idx = byte_q.size();
    d0 = done_cnt;
    req = 2'b01;
    wait_ack(0, "t4 fresh");
    req = 2'b00;
    check_pkt(8'h00, 32'h12345678, 8'h08, "t4 fresh");
    wait_done(d0, 1, "t4 fresh");

    // T5: source 0 sequence wrap over 129 packets, source 1 untouched
    do_reset();
    low_cycles = 2;
    d0 = done_cnt;
    req_data = 64'd0;
    for (int i = 0; i < 129; i++) begin
      req = 2'b01;
      wait_ack(0, $sformatf("t5 #%0d", i + 1));
      req = 2'b00;
      eid = {1'b0, 7'(i)};
      check_pkt(eid, 32'h0, eid, $sformatf("t5 #%0d", i + 1));
    end
    wait_done(d0, 129, "t5");
    d0 = done_cnt;
    req_data = {32'hDEADBEEF, 32'h0};
    req      = 2'b10;
    wait_ack(1, "t5 src1");
    req = 2'b00;
    check_pkt(8'h80, 32'hDEADBEEF, 8'hA2, "t5 src1");
    wait_done(d0, 1, "t5 src1");
    low_cycles = 20;

    // T6: tx_ready stuck high, every byte released by the timeout
    @(negedge clk);
    stuck = 1'b1;
    e0 = en_time_q.size();
    d0 = done_cnt;
    req_data = {32'h0, 32'h12345678};
    req      = 2'b01;
    wait_ack(0, "t6");
    req = 2'b00;
    check_pkt(8'h01, 32'h12345678, 8'h09, "t6");
    wait_done(d0, 1, "t6");
    check("t6 tx_en pulses", 32'(en_time_q.size() - e0), 32'd7);
    for (int k = 1; k < 7; k++) begin
      gap = (en_time_q.size() > e0 + k) ? (en_time_q[e0 + k] - en_time_q[e0 + k - 1]) : 0;
      check($sformatf("t6 gap %0d in 257..300 (gap=%0d)", k, gap),
            32'((gap >= 257) && (gap <= 300)), 32'd1);
    end
    stuck = 1'b0;

    check("tx_en back-to-back count", 32'(dbl_en_err),       32'd0);
    check("tx_en without ready count", 32'(en_not_ready_err), 32'd0);
    check("busy tracking errors",      32'(busy_err),         32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_pkt_scheduler.md
# uart_pkt_scheduler

Shares the single UART transmitter between two 32-bit data producers, such as the ping-timestamp and the status/diagnostic source. It round-robin arbitrates between them and frames each accepted word into a 7-byte packet. It then feeds the UART TX one byte at a time using its ready/enable handshake, so producers never drive the UART directly.

## Interface
- NUM_SRC, 2, number of requesters (fixed at 2 for this revision)
- BUSY_TIMEOUT, 255, clk cycles to wait for tx_ready to drop after a byte is issued
- SYNC_BYTE, 8'hA5, packet header byte
- clk  input  1  system clock (100 MHz)
- reset_b  input  1  asynchronous, active-low reset
- req  input  2  per-source request, level; hold high with data stable until ack
- req_data  input  64  source 0 in [31:0], source 1 in [63:32]
- ack  output  2  one-cycle pulse: that source's data has been captured
- tx_ready  input  1  UART TX ready-to-send
- tx_en  output  1  one-cycle byte-send strobe to the UART
- tx_data  output  8  byte to the UART, valid while tx_en is high
- busy  output  1  high from capture until packet done
- pkt_done  output  1  one-cycle pulse after the last byte is accepted

## Operation
- All outputs are registered. Reset values: ack=0, tx_en=0, tx_data=8'h00, busy=0, pkt_done=0, state=IDLE, both seq counters=0, last_grant=1.
- Because last_grant resets to 1, source 0 wins the first contention.
- Packet byte order:
  - byte 0: SYNC_BYTE
  - byte 1: ID = {src, seq[6:0]}
  - bytes 2-5: data, MSB first
  - byte 6: checksum = XOR of bytes 1-5
- Each source has its own 7-bit seq counter. It increments on that source's pkt_done and wraps 127 -> 0.
- Arbitration happens only in IDLE:
  - one request asserted: grant it;
  - both asserted: grant the source that is not last_grant;
  - the grant updates last_grant.
- States:
  - IDLE: on any req, capture data, ID and checksum, pulse ack[g], set busy, go to SEND.
  - SEND: when tx_ready=1, drive tx_en=1 for exactly one cycle with tx_data=byte[idx], clear the timeout counter, go to WAIT_BUSY. While tx_ready=0, hold with tx_en=0.
  - WAIT_BUSY: go to WAIT_IDLE on tx_ready=0. If the counter reaches BUSY_TIMEOUT, the byte is treated as consumed and the block also goes to WAIT_IDLE.
  - WAIT_IDLE: wait for tx_ready=1. Then, if idx=6: pulse pkt_done, clear busy, increment seq, go to IDLE. Otherwise idx+1 and go to SEND.
- A req that stays high after ack is a new request. It is arbitrated at the next IDLE.
- Changes to req or req_data while busy have no effect on the packet in flight.
- Reset asserted mid-packet immediately returns all state and outputs to reset values. The partial packet is abandoned and not resumed.

## Timing
- req sampled high in IDLE at edge N: ack high during cycle N+1, busy high from N+1.
- First tx_en occurs no earlier than cycle N+2, and only when tx_ready=1.
- tx_en is never high in two consecutive cycles. It is never issued unless tx_ready was 1 in the same cycle.
- pkt_done fires one cycle after WAIT_IDLE sees tx_ready=1 following byte 6. busy falls in that same cycle.
- The earliest next ack is two cycles after pkt_done: IDLE sample, then ack.
- The timeout counter is 8 bits. With BUSY_TIMEOUT=255, a stuck-high tx_ready advances one byte every 257+ cycles.

## Test plan
- Source 0 alone, req_data[31:0]=32'h12345678, UART model holding ready low for 20 clks per byte -> bytes A5 00 12 34 56 78 08, one ack[0] pulse, one pkt_done.
- Source 1 alone, 32'hDEADBEEF, seq 0 -> bytes A5 80 DE AD BE EF A2, busy high throughout.
- Both req high from reset -> source 0 packet first, then source 1. Holding both high for 4 packets gives order 0,1,0,1 and IDs 00,80,01,81.
- Source 0 sends 129 packets -> ID of the 128th is 7F and of the 129th is 00 (wrap); source 1 seq is unaffected.
- tx_ready stuck at 1 -> each byte advances after 255 timeout cycles, 7 tx_en pulses, pkt_done asserted.
- reset_b pulsed low after byte 3 -> all outputs return to reset values in the same cycle. The next req produces a complete fresh packet with the seq unchanged.
